// File: rtl/heartbeat_monitor_if.sv
// Heartbeat monitor signal bundle.
//   enable       master -> slave  monitor enable; low forces the monitor idle
//   hb_in        master -> slave  raw heartbeat square wave, asynchronous to clk
//   edge_pulse   slave -> master  one-cycle pulse per detected hb_in toggle
//   alive        slave -> master  heartbeat locked and within limits
//   lost         slave -> master  heartbeat timed out
//   last_period  slave -> master  clocks between the two most recent toggles
//   fault_count  slave -> master  faults raised while alive, saturating at 255
interface heartbeat_monitor_if #(
    parameter int CNT_W = 27
);
    logic             enable;
    logic             hb_in;
    logic             edge_pulse;
    logic             alive;
    logic             lost;
    logic [CNT_W-1:0] last_period;
    logic [7:0]       fault_count;

    modport master (
        output enable, hb_in,
        input  edge_pulse, alive, lost, last_period, fault_count
    );

    modport slave (
        input  enable, hb_in,
        output edge_pulse, alive, lost, last_period, fault_count
    );
endinterface

// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: synchronises an external square-wave heartbeat, measures
// the interval between its toggles, and tracks whether it is alive, lost or
// still being acquired. Faults raised from the alive state are counted.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  heartbeat_monitor_if.slave (enable, hb_in in; edge_pulse, alive,
//        lost, last_period, fault_count out)
module heartbeat_monitor #(
    parameter int TIMEOUT_COUNTS = 75_000_000,
    parameter int MIN_COUNTS     = 25_000_000,
    parameter int LOCK_EDGES     = 2
) (
    input  logic               clk,
    input  logic               rst,
    heartbeat_monitor_if.slave bus
);
    localparam int CNT_W  = $clog2(TIMEOUT_COUNTS + 1);
    localparam int LOCK_W = $clog2(LOCK_EDGES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(TIMEOUT_COUNTS - 1);
    localparam logic [31:0]       MIN_U       = 32'(MIN_COUNTS);
    localparam logic [LOCK_W-1:0] LOCK_TARGET = LOCK_W'(LOCK_EDGES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_ALIVE,
        S_LOST
    } state_e;

    state_e             state_q, state_d;
    logic               sync0_q, sync0_d;
    logic               sync1_q, sync1_d;
    logic               hist_q, hist_d;
    logic               edge_pulse_q, edge_pulse_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic               have_edge_q, have_edge_d;
    logic [CNT_W-1:0]   last_period_q, last_period_d;
    logic [7:0]         fault_count_q, fault_count_d;

    logic               hb_edge;
    logic [CNT_W:0]     cnt_inc;
    logic [CNT_W-1:0]   cnt_sat;
    logic [LOCK_W-1:0]  lock_inc;
    logic               timeout;
    logic               glitch;
    logic               raise_fault;

    // Both polarities of toggle count as a heartbeat edge.
    assign hb_edge  = sync1_q ^ hist_q;
    assign cnt_inc  = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign cnt_sat  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign lock_inc = lock_q + LOCK_W'(1);
    assign timeout  = !hb_edge && (cnt_q == CNT_MAX);
    // A short interval only means something once a reference edge exists.
    assign glitch   = hb_edge && have_edge_q && (32'(cnt_inc) < MIN_U);

    // NOTE: every output of this block gets a default before any branch so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        sync0_d       = bus.hb_in;
        sync1_d       = sync0_q;
        hist_d        = sync1_q;
        edge_pulse_d  = hb_edge && bus.enable;
        state_d       = state_q;
        cnt_d         = cnt_sat;
        lock_d        = lock_q;
        have_edge_d   = have_edge_q;
        last_period_d = last_period_q;
        raise_fault   = 1'b0;

        if (!bus.enable) begin
            // Disable beats every other event; measurement is abandoned.
            state_d     = S_IDLE;
            cnt_d       = '0;
            lock_d      = '0;
            have_edge_d = 1'b0;
        end else begin
            if (state_q != S_IDLE && hb_edge) begin
                cnt_d         = '0;
                last_period_d = cnt_inc[CNT_W-1:0];
            end

            unique case (state_q)
                S_IDLE: begin
                    state_d     = S_ACQUIRE;
                    cnt_d       = '0;
                    lock_d      = '0;
                    have_edge_d = 1'b0;
                end
                S_ACQUIRE: begin
                    if (hb_edge) begin
                        have_edge_d = 1'b1;
                        if (glitch) begin
                            lock_d = '0;
                        end else if (have_edge_q) begin
                            if (lock_inc == LOCK_TARGET) begin
                                state_d = S_ALIVE;
                                lock_d  = '0;
                            end else begin
                                lock_d = lock_inc;
                            end
                        end
                    end else if (timeout) begin
                        state_d = S_LOST;
                    end
                end
                S_ALIVE: begin
                    if (glitch) begin
                        // The glitching edge becomes the new reference edge.
                        state_d     = S_ACQUIRE;
                        lock_d      = '0;
                        raise_fault = 1'b1;
                    end else if (timeout) begin
                        state_d     = S_LOST;
                        raise_fault = 1'b1;
                    end
                end
                S_LOST: begin
                    if (hb_edge) begin
                        state_d     = S_ACQUIRE;
                        lock_d      = '0;
                        have_edge_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        fault_count_d = fault_count_q;
        if (raise_fault && fault_count_q != 8'hFF) begin
            fault_count_d = fault_count_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync0_q       <= 1'b0;
            sync1_q       <= 1'b0;
            hist_q        <= 1'b0;
            edge_pulse_q  <= 1'b0;
            cnt_q         <= '0;
            lock_q        <= '0;
            have_edge_q   <= 1'b0;
            last_period_q <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync0_q       <= sync0_d;
            sync1_q       <= sync1_d;
            hist_q        <= hist_d;
            edge_pulse_q  <= edge_pulse_d;
            cnt_q         <= cnt_d;
            lock_q        <= lock_d;
            have_edge_q   <= have_edge_d;
            last_period_q <= last_period_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign bus.edge_pulse  = edge_pulse_q;
    assign bus.alive       = (state_q == S_ALIVE);
    assign bus.lost        = (state_q == S_LOST);
    assign bus.last_period = last_period_q;
    assign bus.fault_count = fault_count_q;
endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor with small timing parameters.
// A timestamp-based reference model predicts every output each cycle; a few
// hand-derived literal expectations pin the model at the key moments.
module tb_heartbeat_monitor;
    localparam int T     = 20;
    localparam int MIN   = 5;
    localparam int LOCK  = 2;
    localparam int CNT_W = $clog2(T + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    heartbeat_monitor_if #(.CNT_W(CNT_W)) bus ();

    heartbeat_monitor #(
        .TIMEOUT_COUNTS(T),
        .MIN_COUNTS    (MIN),
        .LOCK_EDGES    (LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ACQ, M_ALIVE, M_LOST} mode_t;
    mode_t mode;
    int    cyc;
    int    ref_cyc;     // cycle at which the current interval started counting
    int    lock_n;
    bit    have;
    int    last_p;
    int    faults;
    bit    pulse;
    bit    hbq[$];      // hb_in as applied before each of the last three edges

    task automatic model_reset();
        hbq     = '{1'b0, 1'b0, 1'b0};
        mode    = M_IDLE;
        ref_cyc = cyc;
        lock_n  = 0;
        have    = 1'b0;
        last_p  = 0;
        faults  = 0;
        pulse   = 1'b0;
    endtask

    // Advance the model across one rising edge given the inputs held at it.
    task automatic model_step(input bit en, input bit hb);
        bit e, short_gap, expired;
        int dt, cnt;
        e   = (hbq[1] != hbq[0]);    // hb_in seen two and three edges ago differ
        dt  = cyc - ref_cyc;
        cnt = (mode == M_IDLE) ? 0 : ((dt > T - 1) ? T - 1 : dt);
        short_gap = have && (cnt + 1 < MIN);
        expired   = !e && (cnt == T - 1);
        pulse = e && en;
        if (!en) begin
            mode = M_IDLE; lock_n = 0; have = 1'b0;
        end else if (mode == M_IDLE) begin
            mode = M_ACQ; ref_cyc = cyc + 1; lock_n = 0; have = 1'b0;
        end else begin
            if (e) begin
                last_p  = cnt + 1;
                ref_cyc = cyc + 1;
            end
            case (mode)
                M_ACQ: begin
                    if (e) begin
                        if (!have) have = 1'b1;
                        else if (short_gap) lock_n = 0;
                        else begin
                            lock_n++;
                            if (lock_n == LOCK) mode = M_ALIVE;
                        end
                    end else if (expired) mode = M_LOST;
                end
                M_ALIVE: begin
                    if (e && short_gap) begin
                        mode = M_ACQ; lock_n = 0;
                        if (faults < 255) faults++;
                    end else if (expired) begin
                        mode = M_LOST;
                        if (faults < 255) faults++;
                    end
                end
                M_LOST: begin
                    if (e) begin mode = M_ACQ; have = 1'b1; lock_n = 0; end
                end
                default: ;
            endcase
        end
        hbq.push_back(hb);
        void'(hbq.pop_front());
    endtask

    task automatic compare_all();
        check("edge_pulse",  bus.edge_pulse,  pulse);
        check("alive",       bus.alive,       mode == M_ALIVE);
        check("lost",        bus.lost,        mode == M_LOST);
        check("last_period", bus.last_period, last_p);
        check("fault_count", bus.fault_count, faults);
    endtask

    // ---------------- stimulus helpers ----------------
    bit en_lvl = 1'b1;
    bit hb_lvl = 1'b0;

    // Called at a falling edge: drive, predict, cross one rising edge, compare.
    task automatic tick(input bit en, input bit hb, input bit r);
        rst        = r;
        bus.enable = en;
        bus.hb_in  = hb;
        if (r) model_reset();
        else   model_step(en, hb);
        cyc++;
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick(en_lvl, hb_lvl, 1'b0);
    endtask

    task automatic toggle_now();
        hb_lvl = ~hb_lvl;
        tick(en_lvl, hb_lvl, 1'b0);
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b1;
        #1;
        check("async_rst_alive", bus.alive, 0);
        check("async_rst_lost",  bus.lost, 0);
        check("async_rst_pulse", bus.edge_pulse, 0);
        check("async_rst_period", bus.last_period, 0);
        check("async_rst_faults", bus.fault_count, 0);
        model_reset();
        cyc++;
        @(posedge clk);
        @(negedge clk);
        compare_all();
        tick(en_lvl, hb_lvl, 1'b0);
    endtask

    initial begin
        cyc        = 0;
        rst        = 1'b1;
        bus.enable = 1'b1;
        bus.hb_in  = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();

        // Reset held while hb_in toggles: everything stays cleared.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, i[0], 1'b1);
            check("rst_alive", bus.alive, 0);
            check("rst_lost",  bus.lost, 0);
            check("rst_pulse", bus.edge_pulse, 0);
        end
        hb_lvl = 1'b0;
        tick(1'b1, 1'b0, 1'b0);     // release; FSM enters ACQUIRE here
        check("post_rst_alive", bus.alive, 0);

        // Lock on 10-clock toggles.
        for (int i = 0; i < 2; i++) begin toggle_now(); hold(9); end
        toggle_now();
        hold(1);
        check("lock_pulse_early", bus.edge_pulse, 0);
        check("lock_alive_early", bus.alive, 0);
        hold(1);                    // third rising edge after the toggle
        check("lock_pulse",  bus.edge_pulse, 1);
        check("lock_alive",  bus.alive, 1);
        check("lock_period", bus.last_period, 10);
        check("lock_lost",   bus.lost, 0);
        hold(1);
        check("lock_pulse_width", bus.edge_pulse, 0);

        // Loss: frozen heartbeat, lost 20 clocks after the last edge pulse.
        hold(18);
        check("loss_not_yet", bus.lost, 0);
        check("loss_alive_still", bus.alive, 1);
        hold(1);
        check("loss_lost",   bus.lost, 1);
        check("loss_alive",  bus.alive, 0);
        check("loss_faults", bus.fault_count, 1);

        // Recovery from LOST.
        toggle_now(); hold(2);
        check("recov_acq_lost",  bus.lost, 0);
        check("recov_acq_alive", bus.alive, 0);
        hold(7);
        toggle_now(); hold(9);
        toggle_now(); hold(2);
        check("recov_alive",  bus.alive, 1);
        check("recov_period", bus.last_period, 10);
        hold(7);

        // Glitch while alive, then a second glitch while acquiring.
        toggle_now(); hold(2);
        toggle_now(); hold(2);
        check("glitch_alive",  bus.alive, 0);
        check("glitch_faults", bus.fault_count, 2);
        check("glitch_period", bus.last_period, 3);
        toggle_now(); hold(2);
        check("glitch2_faults", bus.fault_count, 2);
        hold(7);
        toggle_now(); hold(9);
        check("relock_not_yet", bus.alive, 0);
        toggle_now(); hold(2);
        check("relock_alive", bus.alive, 1);

        // Disable while alive.
        en_lvl = 1'b0;
        hold(1);
        check("dis_alive",  bus.alive, 0);
        check("dis_period", bus.last_period, 10);
        check("dis_faults", bus.fault_count, 2);
        toggle_now(); hold(4);
        en_lvl = 1'b1;
        hold(2);

        // Randomised intervals with occasional disables and one async reset.
        for (int i = 0; i < 150; i++) begin
            toggle_now();
            hold($urandom_range(0, 24));
            if ($urandom_range(0, 15) == 0) begin
                en_lvl = 1'b0;
                hold($urandom_range(1, 4));
                en_lvl = 1'b1;
            end
            if (i == 75) async_reset_check();
        end

        // Saturation: 256 alive-to-lost cycles from a clean reset.
        tick(1'b1, hb_lvl, 1'b1);
        tick(1'b1, hb_lvl, 1'b0);
        hold(1);
        for (int i = 0; i < 256; i++) begin
            toggle_now(); hold(9);
            toggle_now(); hold(9);
            toggle_now(); hold(24);
            if (i == 0)   check("sat_first",  bus.fault_count, 1);
            if (i == 254) check("sat_reach",  bus.fault_count, 255);
        end
        check("sat_final", bus.fault_count, 255);
        check("sat_lost",  bus.lost, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
